// File: rtl/tl_buffer_pkg.sv
// Shared TileLink field widths and defaults for the A/D channel queue buffer.
package tl_buffer_pkg;

    localparam int OPCODE_W  = 3;
    localparam int A_PARAM_W = 3;
    localparam int D_PARAM_W = 2;

    localparam int DEF_ADDR_W   = 28;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SOURCE_W = 5;
    localparam int DEF_SIZE_W   = 4;
    localparam int DEF_DEPTH    = 2;

    // Occupancy counter width: enough to hold DEPTH itself, never narrower than 1 bit.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tl_queue.sv
// Generic FIFO queue with optional same-cycle bypass (FLOW) and full-but-draining
// acceptance (PIPE); DEPTH of 0 degenerates to a plain wire.
module tl_queue
    import tl_buffer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH,
    parameter int FLOW  = 0,
    parameter int PIPE  = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enq_valid,
    output logic                        enq_ready,
    input  logic [WIDTH-1:0]            enq_bits,
    output logic                        deq_valid,
    input  logic                        deq_ready,
    output logic [WIDTH-1:0]            deq_bits,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int CNT_W = cnt_width(DEPTH);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            assign enq_ready = deq_ready;
            assign deq_valid = enq_valid;
            assign deq_bits  = enq_bits;
            assign count     = '0;
        end else begin : g_fifo
            localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

            logic [WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic             empty;
            logic             full;
            logic             bypass;
            logic             do_enq;
            logic             do_deq;

            assign empty     = (count_reg == '0);
            assign full      = (count_reg == CNT_W'(DEPTH));
            assign enq_ready = !full || ((PIPE != 0) && deq_ready);
            assign deq_valid = !empty || ((FLOW != 0) && enq_valid);
            assign deq_bits  = ((FLOW != 0) && empty) ? enq_bits : mem[rd_ptr_reg];
            assign count     = count_reg;

            // A beat that flows straight through an empty queue never touches storage.
            assign bypass = (FLOW != 0) && empty && deq_ready;
            assign do_enq = enq_valid && enq_ready && !bypass;
            assign do_deq = deq_valid && deq_ready && !empty;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (do_enq) begin
                        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
                    end
                    if (do_deq) begin
                        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
                    end
                    if (do_enq && !do_deq) begin
                        count_reg <= count_reg + 1'b1;
                    end else if (!do_enq && do_deq) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
            end

            // Storage is deliberately left out of reset; count/pointers gate its use.
            always_ff @(posedge clock) begin
                if (do_enq) begin
                    mem[wr_ptr_reg] <= enq_bits;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tl_queue_buffer.sv
// TileLink buffer: independent A (in->out) and D (out->in) channel queues.
module tl_queue_buffer
    import tl_buffer_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SOURCE_W = DEF_SOURCE_W,
    parameter int SIZE_W   = DEF_SIZE_W,
    parameter int A_DEPTH  = DEF_DEPTH,
    parameter int D_DEPTH  = DEF_DEPTH,
    parameter int A_FLOW   = 0,
    parameter int D_FLOW   = 0,
    parameter int A_PIPE   = 0,
    parameter int D_PIPE   = 0
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic                          auto_in_a_valid,
    output logic                          auto_in_a_ready,
    input  logic [OPCODE_W-1:0]           auto_in_a_bits_opcode,
    input  logic [A_PARAM_W-1:0]          auto_in_a_bits_param,
    input  logic [SIZE_W-1:0]             auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0]           auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]             auto_in_a_bits_address,
    input  logic [DATA_W/8-1:0]           auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]             auto_in_a_bits_data,
    input  logic                          auto_in_a_bits_corrupt,

    output logic                          auto_out_a_valid,
    input  logic                          auto_out_a_ready,
    output logic [OPCODE_W-1:0]           auto_out_a_bits_opcode,
    output logic [A_PARAM_W-1:0]          auto_out_a_bits_param,
    output logic [SIZE_W-1:0]             auto_out_a_bits_size,
    output logic [SOURCE_W-1:0]           auto_out_a_bits_source,
    output logic [ADDR_W-1:0]             auto_out_a_bits_address,
    output logic [DATA_W/8-1:0]           auto_out_a_bits_mask,
    output logic [DATA_W-1:0]             auto_out_a_bits_data,
    output logic                          auto_out_a_bits_corrupt,

    input  logic                          auto_out_d_valid,
    output logic                          auto_out_d_ready,
    input  logic [OPCODE_W-1:0]           auto_out_d_bits_opcode,
    input  logic [D_PARAM_W-1:0]          auto_out_d_bits_param,
    input  logic [SIZE_W-1:0]             auto_out_d_bits_size,
    input  logic [SOURCE_W-1:0]           auto_out_d_bits_source,
    input  logic                          auto_out_d_bits_sink,
    input  logic                          auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]             auto_out_d_bits_data,
    input  logic                          auto_out_d_bits_corrupt,

    output logic                          auto_in_d_valid,
    input  logic                          auto_in_d_ready,
    output logic [OPCODE_W-1:0]           auto_in_d_bits_opcode,
    output logic [D_PARAM_W-1:0]          auto_in_d_bits_param,
    output logic [SIZE_W-1:0]             auto_in_d_bits_size,
    output logic [SOURCE_W-1:0]           auto_in_d_bits_source,
    output logic                          auto_in_d_bits_sink,
    output logic                          auto_in_d_bits_denied,
    output logic [DATA_W-1:0]             auto_in_d_bits_data,
    output logic                          auto_in_d_bits_corrupt,

    output logic [cnt_width(A_DEPTH)-1:0] a_count,
    output logic [cnt_width(D_DEPTH)-1:0] d_count
);

    localparam int MASK_W = DATA_W / 8;
    localparam int A_W = OPCODE_W + A_PARAM_W + SIZE_W + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;
    localparam int D_W = OPCODE_W + D_PARAM_W + SIZE_W + SOURCE_W + 1 + 1 + DATA_W + 1;

    logic [A_W-1:0] a_enq_bits;
    logic [A_W-1:0] a_deq_bits;
    logic [D_W-1:0] d_enq_bits;
    logic [D_W-1:0] d_deq_bits;

    // Field order is shared by pack and unpack, so the queue sees one opaque vector.
    assign a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                         auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                         auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq_bits;

    assign d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                         auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                         auto_out_d_bits_data, auto_out_d_bits_corrupt};
    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
            auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq_bits;

    tl_queue #(
        .WIDTH (A_W),
        .DEPTH (A_DEPTH),
        .FLOW  (A_FLOW),
        .PIPE  (A_PIPE)
    ) u_a_queue (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_in_a_valid),
        .enq_ready (auto_in_a_ready),
        .enq_bits  (a_enq_bits),
        .deq_valid (auto_out_a_valid),
        .deq_ready (auto_out_a_ready),
        .deq_bits  (a_deq_bits),
        .count     (a_count)
    );

    tl_queue #(
        .WIDTH (D_W),
        .DEPTH (D_DEPTH),
        .FLOW  (D_FLOW),
        .PIPE  (D_PIPE)
    ) u_d_queue (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_out_d_valid),
        .enq_ready (auto_out_d_ready),
        .enq_bits  (d_enq_bits),
        .deq_valid (auto_in_d_valid),
        .deq_ready (auto_in_d_ready),
        .deq_bits  (d_deq_bits),
        .count     (d_count)
    );

endmodule

// File: tb/tb_tl_queue_buffer.sv
// Three differently configured buffers share one stimulus stream; a queue-based
// reference model predicts every channel's handshake, bits and occupancy.
module tb_tl_queue_buffer;
    import tl_buffer_pkg::*;

    localparam int NDUT = 3;
    localparam int NCH  = 2 * NDUT;
    localparam int A_W  = 80;
    localparam int D_W  = 49;

    // Channel ch = 2*dut + (0 for A, 1 for D).
    function automatic int ch_depth(input int ch);
        case (ch)
            0: return 2;
            1: return 3;
            2: return 0;
            3: return 2;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int ch_flow(input int ch);
        return (ch >= 4) ? 1 : 0;
    endfunction

    function automatic int ch_pipe(input int ch);
        return (ch == 3 || ch == 5) ? 1 : 0;
    endfunction

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic a_valid = 1'b0;
    logic d_valid = 1'b0;
    logic out_a_ready = 1'b0;
    logic in_d_ready = 1'b0;
    logic [A_W-1:0] a_in = '0;
    logic [D_W-1:0] d_in = '0;

    logic [NCH-1:0]    enq_rdy;
    logic [NCH-1:0]    deq_vld;
    logic [NCH*80-1:0] deq_bits_flat;
    logic [NCH*4-1:0]  cnt_flat;

    initial forever #5 clock = ~clock;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int AD = ch_depth(2 * gi);
        localparam int DD = ch_depth(2 * gi + 1);

        logic [2:0]  oa_opcode;
        logic [2:0]  oa_param;
        logic [3:0]  oa_size;
        logic [4:0]  oa_source;
        logic [27:0] oa_address;
        logic [3:0]  oa_mask;
        logic [31:0] oa_data;
        logic        oa_corrupt;
        logic [2:0]  id_opcode;
        logic [1:0]  id_param;
        logic [3:0]  id_size;
        logic [4:0]  id_source;
        logic        id_sink;
        logic        id_denied;
        logic [31:0] id_data;
        logic        id_corrupt;
        logic [cnt_width(AD)-1:0] a_cnt;
        logic [cnt_width(DD)-1:0] d_cnt;

        tl_queue_buffer #(
            .A_DEPTH (AD),
            .D_DEPTH (DD),
            .A_FLOW  (ch_flow(2 * gi)),
            .D_FLOW  (ch_flow(2 * gi + 1)),
            .A_PIPE  (ch_pipe(2 * gi)),
            .D_PIPE  (ch_pipe(2 * gi + 1))
        ) u_dut (
            .clock                   (clock),
            .reset                   (reset),
            .auto_in_a_valid         (a_valid),
            .auto_in_a_ready         (enq_rdy[2*gi]),
            .auto_in_a_bits_opcode   (a_in[79:77]),
            .auto_in_a_bits_param    (a_in[76:74]),
            .auto_in_a_bits_size     (a_in[73:70]),
            .auto_in_a_bits_source   (a_in[69:65]),
            .auto_in_a_bits_address  (a_in[64:37]),
            .auto_in_a_bits_mask     (a_in[36:33]),
            .auto_in_a_bits_data     (a_in[32:1]),
            .auto_in_a_bits_corrupt  (a_in[0]),
            .auto_out_a_valid        (deq_vld[2*gi]),
            .auto_out_a_ready        (out_a_ready),
            .auto_out_a_bits_opcode  (oa_opcode),
            .auto_out_a_bits_param   (oa_param),
            .auto_out_a_bits_size    (oa_size),
            .auto_out_a_bits_source  (oa_source),
            .auto_out_a_bits_address (oa_address),
            .auto_out_a_bits_mask    (oa_mask),
            .auto_out_a_bits_data    (oa_data),
            .auto_out_a_bits_corrupt (oa_corrupt),
            .auto_out_d_valid        (d_valid),
            .auto_out_d_ready        (enq_rdy[2*gi+1]),
            .auto_out_d_bits_opcode  (d_in[48:46]),
            .auto_out_d_bits_param   (d_in[45:44]),
            .auto_out_d_bits_size    (d_in[43:40]),
            .auto_out_d_bits_source  (d_in[39:35]),
            .auto_out_d_bits_sink    (d_in[34]),
            .auto_out_d_bits_denied  (d_in[33]),
            .auto_out_d_bits_data    (d_in[32:1]),
            .auto_out_d_bits_corrupt (d_in[0]),
            .auto_in_d_valid         (deq_vld[2*gi+1]),
            .auto_in_d_ready         (in_d_ready),
            .auto_in_d_bits_opcode   (id_opcode),
            .auto_in_d_bits_param    (id_param),
            .auto_in_d_bits_size     (id_size),
            .auto_in_d_bits_source   (id_source),
            .auto_in_d_bits_sink     (id_sink),
            .auto_in_d_bits_denied   (id_denied),
            .auto_in_d_bits_data     (id_data),
            .auto_in_d_bits_corrupt  (id_corrupt),
            .a_count                 (a_cnt),
            .d_count                 (d_cnt)
        );

        assign deq_bits_flat[(2*gi)*80 +: 80] = {oa_opcode, oa_param, oa_size, oa_source,
                                                 oa_address, oa_mask, oa_data, oa_corrupt};
        assign deq_bits_flat[(2*gi+1)*80 +: 80] = {31'd0, id_opcode, id_param, id_size, id_source,
                                                   id_sink, id_denied, id_data, id_corrupt};
        assign cnt_flat[(2*gi)*4 +: 4]   = 4'(a_cnt);
        assign cnt_flat[(2*gi+1)*4 +: 4] = 4'(d_cnt);
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [79:0] mq [NCH][$];
    int d_seq = 0;
    int d_got = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from queue occupancy; then the queue is advanced
    // with the handshakes that will complete at the coming rising edge.
    task automatic model_ch(input int ch);
        int dep, n;
        logic ev, dr, e_rdy, e_vld, do_deq, do_enq;
        logic [79:0] eb, e_bits;
        dep = ch_depth(ch);
        n   = mq[ch].size();
        if (ch % 2 == 0) begin
            ev = a_valid; eb = 80'(a_in); dr = out_a_ready;
        end else begin
            ev = d_valid; eb = 80'(d_in); dr = in_d_ready;
        end
        if (dep == 0) begin
            e_rdy = dr; e_vld = ev; e_bits = eb;
        end else begin
            e_rdy  = (n < dep) || (ch_pipe(ch) == 1 && dr);
            e_vld  = (n > 0) || (ch_flow(ch) == 1 && ev);
            e_bits = (n > 0) ? mq[ch][0] : eb;
        end
        chk($sformatf("ch%0d_ready", ch), 80'(enq_rdy[ch]), 80'(e_rdy));
        chk($sformatf("ch%0d_valid", ch), 80'(deq_vld[ch]), 80'(e_vld));
        chk($sformatf("ch%0d_count", ch), 80'(cnt_flat[ch*4 +: 4]), 80'(n));
        if (e_vld || dep == 0) begin
            chk($sformatf("ch%0d_bits", ch), deq_bits_flat[ch*80 +: 80], e_bits);
        end
        do_deq = e_vld && dr;
        do_enq = ev && e_rdy;
        if (reset && dep > 0) begin
            if (do_deq && n > 0) void'(mq[ch].pop_front());
            if (do_enq && !(do_deq && n == 0)) mq[ch].push_back(eb);
        end
    endtask

    task automatic settle();
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (!reset) mq[ch].delete();
            model_ch(ch);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [A_W-1:0] a_beat(input int k, input logic [27:0] addr);
        return {3'd4, 3'd0, 4'd2, 5'(k), addr, 4'hf, 32'($urandom), 1'b0};
    endfunction

    initial begin
        // Reset state
        out_a_ready = 1'b1;
        in_d_ready  = 1'b1;
        settle();
        chk("rst_a_count", 80'(cnt_flat[3:0]), 80'd0);
        chk("rst_in_a_ready", 80'(enq_rdy[0]), 80'd1);
        chk("rst_out_a_valid", 80'(deq_vld[0]), 80'd0);
        chk("rst_out_d_ready", 80'(enq_rdy[1]), 80'd1);
        tick();
        settle();
        tick();
        reset = 1'b1;

        // Three A beats against a stalled sink
        out_a_ready = 1'b0;
        a_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in = a_beat(k, 28'h100 + 28'(k));
            settle();
            tick();
        end
        settle();
        chk("fill_a_count", 80'(cnt_flat[3:0]), 80'd2);
        chk("fill_in_a_ready", 80'(enq_rdy[0]), 80'd0);
        tick();
        out_a_ready = 1'b1;
        settle();
        chk("drain_first_addr", 80'(deq_bits_flat[64:37]), 80'h100);
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            tick();
        end

        // Flow-through on an empty queue
        a_valid = 1'b1;
        a_in = a_beat(7, 28'h1234560);
        settle();
        chk("flow_out_valid", 80'(deq_vld[4]), 80'd1);
        chk("flow_addr", 80'(deq_bits_flat[4*80+37 +: 28]), 80'h1234560);
        chk("flow_count", 80'(cnt_flat[19:16]), 80'd0);
        tick();
        a_valid = 1'b0;
        settle();
        chk("flow_count_after", 80'(cnt_flat[19:16]), 80'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            settle();
            tick();
        end

        // Full D queue with PIPE accepts while draining
        d_valid = 1'b1;
        in_d_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d_in = D_W'({$urandom, $urandom});
            settle();
            tick();
        end
        in_d_ready = 1'b1;
        d_in = D_W'({$urandom, $urandom});
        settle();
        chk("pipe_count", 80'(cnt_flat[15:12]), 80'd2);
        chk("pipe_out_d_ready", 80'(enq_rdy[3]), 80'd1);
        chk("pipe_in_d_valid", 80'(deq_vld[3]), 80'd1);
        tick();
        d_valid = 1'b0;
        settle();
        chk("pipe_count_after", 80'(cnt_flat[15:12]), 80'd2);
        tick();
        for (int k = 0; k < 4; k++) begin
            settle();
            tick();
        end

        // Reset while A holds two beats
        out_a_ready = 1'b0;
        a_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_in = a_beat(k, 28'h200 + 28'(k));
            settle();
            tick();
        end
        settle();
        chk("prerst_a_count", 80'(cnt_flat[3:0]), 80'd2);
        tick();
        reset = 1'b0;
        a_valid = 1'b0;
        settle();
        chk("midrst_a_count", 80'(cnt_flat[3:0]), 80'd0);
        chk("midrst_out_a_valid", 80'(deq_vld[0]), 80'd0);
        tick();
        reset = 1'b1;
        out_a_ready = 1'b1;
        settle();
        chk("postrst_no_replay", 80'(deq_vld[0]), 80'd0);
        tick();

        // Random stalls on every channel; D sources 0..9 must arrive in order at the depth-3 queue
        for (int cyc = 0; cyc < 300; cyc++) begin
            a_valid     = 1'($urandom_range(0, 1));
            out_a_ready = 1'($urandom_range(0, 1));
            in_d_ready  = ($urandom_range(0, 2) != 0);
            a_in        = A_W'({$urandom, $urandom, $urandom});
            d_valid     = (d_seq < 10) && ($urandom_range(0, 2) != 0);
            d_in        = D_W'({$urandom, $urandom});
            d_in[39:35] = 5'(d_seq);
            settle();
            if (d_valid && enq_rdy[1]) d_seq++;
            if (deq_vld[1] && in_d_ready) begin
                chk("d_order", 80'(deq_bits_flat[80+35 +: 5]), 80'(d_got));
                d_got++;
            end
            tick();
        end
        chk("d_delivered", 80'(d_got), 80'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tl_queue_buffer.md
TL_QUEUE_BUFFER -- requirements
Module: tl_queue_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, A-channel address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width on A and D; mask width is DATA_W/8.
REQ-003 SHALL have parameter SOURCE_W, default 5, source id width.
REQ-004 SHALL have parameter SIZE_W, default 4, size field width.
REQ-005 SHALL have parameters A_DEPTH and D_DEPTH, default 2 each, range 0..8; 0 gives a combinational pass-through channel.
REQ-006 SHALL have parameters A_FLOW and D_FLOW, default 0; 1 gives same-cycle bypass when the channel queue is empty.
REQ-007 SHALL have parameters A_PIPE and D_PIPE, default 0; 1 gives ready while full if the output is dequeuing.
REQ-008 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports auto_in_a_valid and auto_in_a_bits_{opcode,param,size,source,address,mask,data,corrupt}, input, 1/3/3/SIZE_W/SOURCE_W/ADDR_W/DATA_W/8/DATA_W/1, upstream A request.
REQ-011 SHALL have port auto_in_a_ready, output, 1, A accept.
REQ-012 SHALL have ports auto_out_a_valid and auto_out_a_bits_*, output, same widths, downstream A request; auto_out_a_ready, input, 1.
REQ-013 SHALL have ports auto_out_d_valid and auto_out_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}, input, 1/3/2/SIZE_W/SOURCE_W/1/1/DATA_W/1, downstream D response; auto_out_d_ready, output, 1.
REQ-014 SHALL have ports auto_in_d_valid and auto_in_d_bits_*, output, same widths; auto_in_d_ready, input, 1.
REQ-015 SHALL have ports a_count and d_count, output, $clog2(DEPTH+1) (min 1), current channel occupancy.

Function
REQ-016 Each channel (A: in->out, D: out->in) SHALL be an independent FIFO of its DEPTH entries holding the full bits bundle.
REQ-017 Enqueue SHALL occur on enq_valid && enq_ready; dequeue SHALL occur on deq_valid && deq_ready.
REQ-018 enq_ready SHALL be count<DEPTH, or (PIPE && deq_ready) when count==DEPTH.
REQ-019 deq_valid SHALL be count>0, or (FLOW && enq_valid) when count==0; deq bits SHALL be the head entry, or the enq bits when bypassing.
REQ-020 An element bypassed under FLOW and dequeued in the same cycle SHALL not be written to storage or change count.
REQ-021 Latency SHALL be 1 cycle enq-to-deq-valid with FLOW=0, 0 cycles with FLOW=1 on an empty queue.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers, including when full with PIPE=1.
REQ-023 Read/write pointers SHALL wrap from DEPTH-1 to 0; non-power-of-two DEPTH SHALL be supported.
REQ-024 count SHALL never exceed DEPTH or go below 0; order SHALL be strictly FIFO with no drop or duplication.
REQ-025 DEPTH=0 SHALL wire valid, ready and bits straight through with count tied to 0 and no storage.
REQ-026 A valid output SHALL hold stable bits until accepted.

Reset
REQ-027 On reset low, both counts and pointers SHALL clear asynchronously; auto_out_a_valid and auto_in_d_valid SHALL be 0 (FLOW bypass excepted).
REQ-028 auto_in_a_ready and auto_out_d_ready SHALL be 1 during and after reset for DEPTH>=1; storage entries SHALL not be reset.
REQ-029 Reset asserted mid-transfer SHALL discard all queued entries.

Structure
REQ-030 The TL opcode widths, D param width and default parameter constants SHALL live in shared package tl_buffer_pkg.
REQ-031 One sub-module tl_queue (parameters WIDTH, DEPTH, FLOW, PIPE; packed bits) SHALL be instantiated once per channel.

Verification
REQ-032 A_DEPTH=2, out_a_ready=0, three A beats offered -> 2 accepted, a_count=2, in_a_ready=0; ready=1 -> beats exit in order.
REQ-033 A_FLOW=1, empty, in_a_valid with address 0x123_4560 and out_a_ready=1 -> out_a_valid same cycle, a_count stays 0.
REQ-034 D_DEPTH=2, D_PIPE=1, full, in_d_ready=1 and new beat -> enqueue and dequeue same cycle, d_count stays 2.
REQ-035 D_DEPTH=3, 10 random-stall beats with sources 0..9 -> delivered 0..9 in order, pointer wrap exercised, no loss.
REQ-036 Reset low with a_count=2 -> a_count=0 and out_a_valid=0 immediately; queued beats not replayed.
REQ-037 A_DEPTH=0 -> all A signals equal their inputs combinationally on every cycle.
